// File: rtl/flop_share_ctrl.sv
// Round-robin front end that time-shares one combinational 13-bit float adder
// among NREQ requesters: accept operands, let the adder settle, capture, respond.
module flop_share_ctrl #(
  parameter int W    = 13,
  parameter int NREQ = 4,
  parameter int CNTW = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*W-1:0]  req_a,
  input  logic [NREQ*W-1:0]  req_b,
  output logic [NREQ-1:0]    rsp_valid,
  input  logic [NREQ-1:0]    rsp_ready,
  output logic [W-1:0]       rsp_data,
  output logic [W-1:0]       add_a,
  output logic [W-1:0]       add_b,
  input  logic [W-1:0]       add_sum,
  output logic               busy,
  output logic [CNTW-1:0]    op_count,
  output logic [1:0]         dbgState
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t          state, stateNext;
  logic [IDW-1:0]  rrPtr, idReg, grantIdx, nextPtr;
  logic            grantFound, rspFire;
  logic [NREQ-1:0] grantOneHot, rspValidReg;
  logic [W-1:0]    aReg, bReg, resReg, selA, selB;
  logic [CNTW-1:0] opCount;
  int              cand;

  // Handshakes (req and rsp): a transfer happens on the rising edge where
  // valid and ready are both high; rsp_valid/rsp_data hold until that edge.

  // First valid requester at or after rrPtr, wrapping modulo NREQ.
  always_comb begin
    grantIdx   = '0;
    grantFound = 1'b0;
    cand       = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(rrPtr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!grantFound && req_valid[cand[IDW-1:0]]) begin
        grantIdx   = cand[IDW-1:0];
        grantFound = 1'b1;
      end
    end
  end

  assign grantOneHot = NREQ'(1) << grantIdx;
  assign nextPtr     = (grantIdx == IDW'(NREQ - 1)) ? '0 : grantIdx + 1'b1;

  always_comb begin
    selA = '0;
    selB = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grantIdx == IDW'(k)) begin
        selA = req_a[k*W +: W];
        selB = req_b[k*W +: W];
      end
    end
  end

  // Only the granted requester's rsp_ready can complete the response.
  assign rspFire = (state == RESP) && rsp_ready[idReg];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (grantFound) begin
          req_ready = grantOneHot;
          stateNext = ISSUE;
        end
      end
      ISSUE:   stateNext = CAPTURE;
      CAPTURE: stateNext = RESP;
      RESP:    if (rspFire) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aReg        <= '0;
      bReg        <= '0;
      idReg       <= '0;
      rrPtr       <= '0;
      resReg      <= '0;
      rspValidReg <= '0;
      opCount     <= '0;
    end else begin
      if (state == IDLE && grantFound) begin
        aReg  <= selA;
        bReg  <= selB;
        idReg <= grantIdx;
        rrPtr <= nextPtr;
      end
      // Adder has had the whole ISSUE cycle to settle by this edge.
      if (state == CAPTURE) begin
        resReg      <= add_sum;
        rspValidReg <= NREQ'(1) << idReg;
      end
      if (rspFire) begin
        rspValidReg <= '0;
        opCount     <= opCount + 1'b1;
      end
    end
  end

  assign add_a     = aReg;
  assign add_b     = bReg;
  assign rsp_valid = rspValidReg;
  assign rsp_data  = resReg;
  assign busy      = (state != IDLE);
  assign op_count  = opCount;
  assign dbgState  = state;

endmodule
